// File: rtl/bp_mc_req_mailbox.sv
// Word mailbox between the manycore request PISO and BP software: a circular word buffer
// drained through two MMIO registers (FIFO pop and entry count) with a single-outstanding response.
module bp_mc_req_mailbox #(
    parameter int word_width_p      = 64,
    parameter int els_p             = 16,
    parameter int mmio_addr_width_p = 24,
    parameter logic [mmio_addr_width_p-1:0] fifo_addr_p    = 'h0_5000,
    parameter logic [mmio_addr_width_p-1:0] entries_addr_p = 'h0_6000,
    localparam int ptr_w = $clog2(els_p),
    localparam int cnt_w = $clog2(els_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [word_width_p-1:0]      req_data_i,
    input  logic                         req_v_i,
    output logic                         req_ready_and_o,
    input  logic                         mmio_v_i,
    input  logic                         mmio_we_i,
    input  logic [mmio_addr_width_p-1:0] mmio_addr_i,
    output logic                         mmio_ready_and_o,
    output logic [word_width_p-1:0]      mmio_data_o,
    output logic                         mmio_v_o,
    input  logic                         mmio_yumi_i,
    output logic [cnt_w-1:0]             entries_o,
    output logic                         irq_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [word_width_p-1:0] r_mem [els_p];
    logic [ptr_w-1:0]        r_wr_ptr;
    logic [ptr_w-1:0]        r_rd_ptr;
    logic [cnt_w-1:0]        r_count;
    logic [cnt_w-1:0]        w_count_nxt;
    logic                    r_irq;
    logic [word_width_p-1:0] r_data;
    logic [word_width_p-1:0] w_resp_data;
    logic                    w_push;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_is_fifo;
    logic                    w_is_entries;
    logic                    w_empty;

    // Ready is a function of registered state only: a pop cannot free a slot for a same-cycle push.
    assign req_ready_and_o  = (r_count != cnt_w'(els_p));
    assign mmio_ready_and_o = (r_state == IDLE);
    assign mmio_v_o         = (r_state == RESP);
    assign mmio_data_o      = r_data;
    assign entries_o        = r_count;
    assign irq_o            = r_irq;

    assign w_empty      = (r_count == '0);
    assign w_is_fifo    = (mmio_addr_i == fifo_addr_p);
    assign w_is_entries = (mmio_addr_i == entries_addr_p);
    assign w_push       = req_v_i & req_ready_and_o;
    assign w_accept     = mmio_v_i & mmio_ready_and_o;
    assign w_pop        = w_accept & ~mmio_we_i & w_is_fifo & ~w_empty;

    always_comb begin
        w_resp_data = '0;
        if (!mmio_we_i) begin
            if (w_is_fifo && !w_empty) begin
                w_resp_data = r_mem[r_rd_ptr];
            end else if (w_is_entries) begin
                w_resp_data = word_width_p'(r_count);
            end
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + cnt_w'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - cnt_w'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (mmio_v_i) w_state_nxt = RESP;
            RESP:    if (mmio_yumi_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_w'(1);
            r_count <= w_count_nxt;
            r_irq   <= (w_count_nxt >= cnt_w'(2));
        end
    end

    // Response word is captured at accept and held until software consumes it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_data <= '0;
        end else if (w_accept) begin
            r_data <= w_resp_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= req_data_i;
        end
    end

endmodule

// File: tb/tb_bp_mc_req_mailbox.sv
// Directed and randomized checks of bp_mc_req_mailbox against a queue-based model of the mailbox.
module tb_bp_mc_req_mailbox;

    localparam logic [23:0] FIFO_A = 24'h0_5000;
    localparam logic [23:0] ENT_A  = 24'h0_6000;
    localparam logic [23:0] BAD_A  = 24'h0_7000;
    localparam int          DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req_data;
    logic        req_v;
    logic        req_ready;
    logic        mmio_v;
    logic        mmio_we;
    logic [23:0] mmio_addr;
    logic        mmio_ready;
    logic [63:0] mmio_data;
    logic        mmio_v_o;
    logic        yumi;
    logic [4:0]  entries;
    logic        irq;

    logic [63:0] q[$];
    bit          m_busy;
    logic [63:0] m_data;
    int          errors = 0;
    int          checks = 0;

    bp_mc_req_mailbox dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .req_data_i      (req_data),
        .req_v_i         (req_v),
        .req_ready_and_o (req_ready),
        .mmio_v_i        (mmio_v),
        .mmio_we_i       (mmio_we),
        .mmio_addr_i     (mmio_addr),
        .mmio_ready_and_o(mmio_ready),
        .mmio_data_o     (mmio_data),
        .mmio_v_o        (mmio_v_o),
        .mmio_yumi_i     (yumi),
        .entries_o       (entries),
        .irq_o           (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("entries",    64'(entries),    64'(q.size()));
        chk("irq",        64'(irq),        64'(q.size() >= 2));
        chk("req_ready",  64'(req_ready),  64'(q.size() != DEPTH));
        chk("mmio_v_o",   64'(mmio_v_o),   64'(m_busy));
        chk("mmio_ready", 64'(mmio_ready), 64'(!m_busy));
        if (m_busy) chk("mmio_data", mmio_data, m_data);
    endtask

    // One clock: the model applies the mailbox rules to the current inputs, then outputs are compared.
    task automatic step();
        int          sz;
        bit          push;
        bit          accept;
        bit          pop;
        logic [63:0] d;
        sz     = q.size();
        push   = req_v && (sz != DEPTH);
        accept = mmio_v && !m_busy;
        pop    = 1'b0;
        d      = 64'd0;
        if (accept && !mmio_we) begin
            if (mmio_addr == FIFO_A && sz > 0) begin
                d   = q[0];
                pop = 1'b1;
            end else if (mmio_addr == ENT_A) begin
                d = 64'(sz);
            end
        end
        if (m_busy && yumi) m_busy = 1'b0;
        if (accept) begin
            m_busy = 1'b1;
            m_data = d;
        end
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(req_data);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_mmio(input logic we, input logic [23:0] a, output logic [63:0] data);
        mmio_v    = 1'b1;
        mmio_we   = we;
        mmio_addr = a;
        step();
        mmio_v = 1'b0;
        data   = mmio_data;
        yumi   = 1'b1;
        step();
        yumi = 1'b0;
    endtask

    task automatic push_word(input logic [63:0] w);
        req_v    = 1'b1;
        req_data = w;
        step();
        req_v = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 1'b0;
        m_data = 64'd0;
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] held;
        logic [63:0] w4[4];
        rst       = 1'b1;
        req_v     = 1'b0;
        req_data  = 64'd0;
        mmio_v    = 1'b0;
        mmio_we   = 1'b0;
        mmio_addr = 24'd0;
        yumi      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_data", mmio_data, 64'd0);
        rst = 1'b0;

        // Reset while a response is pending with three words buffered.
        for (int i = 0; i < 3; i++) push_word(64'h1000 + 64'(i));
        mmio_v    = 1'b1;
        mmio_we   = 1'b0;
        mmio_addr = ENT_A;
        step();
        mmio_v = 1'b0;
        chk("t1_pending", mmio_data, 64'd3);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("t1_rst_data", mmio_data, 64'd0);
        #1 rst = 1'b0;
        do_mmio(1'b0, ENT_A, d);
        chk("t1_entries", d, 64'd0);

        // Four words out in arrival order; irq falls once fewer than two remain.
        w4[0] = 64'hA0A0_0000_0000_000A;
        w4[1] = 64'hB0B0_0000_0000_000B;
        w4[2] = 64'hC0C0_0000_0000_000C;
        w4[3] = 64'hD0D0_0000_0000_000D;
        for (int i = 0; i < 4; i++) push_word(w4[i]);
        chk("t2_irq_hi", 64'(irq), 64'd1);
        for (int i = 0; i < 4; i++) begin
            do_mmio(1'b0, FIFO_A, d);
            chk("t2_pop", d, w4[i]);
            if (i == 2) chk("t2_irq_lo", 64'(irq), 64'd0);
        end
        do_mmio(1'b0, ENT_A, d);
        chk("t2_entries", d, 64'd0);

        // Fill to capacity, hold a 17th word, free one slot, then drain across the wrap.
        req_v = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_data = 64'h3000 + 64'(i);
            step();
        end
        chk("t3_full", 64'(req_ready), 64'd0);
        req_data = 64'h3010;
        step();
        step();
        chk("t3_held", 64'(entries), 64'd16);
        do_mmio(1'b0, FIFO_A, d);
        chk("t3_first", d, 64'h3000);
        req_v = 1'b0;
        chk("t3_refill", 64'(entries), 64'd16);
        for (int i = 1; i <= 16; i++) begin
            do_mmio(1'b0, FIFO_A, d);
            chk("t3_order", d, 64'h3000 + 64'(i));
        end

        // Empty FIFO reads return zero; writes change nothing.
        do_mmio(1'b0, FIFO_A, d);
        chk("t4_empty", d, 64'd0);
        push_word(64'h4444);
        do_mmio(1'b1, FIFO_A, d);
        chk("t4_write", d, 64'd0);
        chk("t4_count", 64'(entries), 64'd1);
        do_mmio(1'b0, BAD_A, d);
        chk("t4_unmapped", d, 64'd0);
        do_mmio(1'b0, FIFO_A, d);
        chk("t4_pop", d, 64'h4444);

        // Simultaneous push and pop at five entries.
        for (int i = 0; i < 5; i++) push_word(64'h5000 + 64'(i));
        req_v     = 1'b1;
        req_data  = 64'h5005;
        mmio_v    = 1'b1;
        mmio_we   = 1'b0;
        mmio_addr = FIFO_A;
        step();
        req_v  = 1'b0;
        mmio_v = 1'b0;
        chk("t5_count", 64'(entries), 64'd5);
        chk("t5_data", mmio_data, 64'h5000);
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            do_mmio(1'b0, FIFO_A, d);
            chk("t5_order", d, 64'h5000 + 64'(i));
        end

        // Response held for ten cycles while the stream keeps pushing.
        push_word(64'h6000);
        mmio_v    = 1'b1;
        mmio_addr = ENT_A;
        step();
        mmio_v = 1'b0;
        held   = mmio_data;
        chk("t6_captured", held, 64'd1);
        req_v = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_data = {$urandom, $urandom};
            step();
            chk("t6_stable", mmio_data, held);
        end
        req_v = 1'b0;
        yumi  = 1'b1;
        step();
        yumi = 1'b0;

        // Randomized traffic on both interfaces.
        for (int i = 0; i < 500; i++) begin
            req_v    = 1'($urandom_range(0, 1));
            req_data = {$urandom, $urandom};
            mmio_v   = ($urandom_range(0, 2) == 0);
            mmio_we  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0, 1:    mmio_addr = FIFO_A;
                2:       mmio_addr = ENT_A;
                default: mmio_addr = BAD_A;
            endcase
            yumi = 1'($urandom_range(0, 1));
            step();
        end
        req_v  = 1'b0;
        mmio_v = 1'b0;
        yumi   = 1'b1;
        step();
        yumi = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) do_mmio(1'b0, FIFO_A, d);
        chk("drain_empty", 64'(entries), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
